msrh_lrq_miss_queue: RTL and testbench

Load miss queue (LRQ) for the L1D. Accepts line-miss requests from each LSU pipeline EX2 stage and answers each one in the same cycle with ASSIGNED, CONFLICT or FULL plus an LRQ index, in the form the LDQ entries consume. Issues line refills to L2 and writes each returned line into L1D. Broadcasts lrq_resolve (valid + index one-hot), which moves waiting LDQ entries from LRQ_HAZ back to ISSUE_WAIT.

---
 rtl/msrh_lrq_miss_queue_if.sv | 36 +++
 rtl/msrh_lrq_miss_queue.sv | 138 +++++++++++++
 tb/tb_msrh_lrq_miss_queue.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msrh_lrq_miss_queue_if.sv
// msrh_lrq_miss_queue_if: LSU miss request, L2 refill and L1D fill/resolve signals of the load miss queue.
interface msrh_lrq_miss_queue_if #(
   parameter int LRQ_SIZE     = 4,
   parameter int LSU_INST_NUM = 2,
   parameter int PADDR_W      = 56,
   parameter int LINE_W       = 512
);
   localparam int TAG_W = $clog2(LRQ_SIZE);
   logic [LSU_INST_NUM-1:0]          i_req_valid;
   logic [LSU_INST_NUM*PADDR_W-1:0]  i_req_paddr;
   logic [LSU_INST_NUM*2-1:0]        o_resp_typ;
   logic [LSU_INST_NUM*LRQ_SIZE-1:0] o_resp_index_oh;
   logic                             o_l2_req_valid;
   logic [PADDR_W-1:0]               o_l2_req_paddr;
   logic [TAG_W-1:0]                 o_l2_req_tag;
   logic                             i_l2_req_ready;
   logic                             i_l2_resp_valid;
   logic [TAG_W-1:0]                 i_l2_resp_tag;
   logic [LINE_W-1:0]                i_l2_resp_data;
   logic                             o_l1d_wr_valid;
   logic [PADDR_W-1:0]               o_l1d_wr_paddr;
   logic [LINE_W-1:0]                o_l1d_wr_data;
   logic                             o_lrq_resolve_valid;
   logic [LRQ_SIZE-1:0]              o_lrq_resolve_index_oh;
   logic                             o_lrq_full;
   modport slave (
      input  i_req_valid, i_req_paddr, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_tag, i_l2_resp_data,
      output o_resp_typ, o_resp_index_oh, o_l2_req_valid, o_l2_req_paddr, o_l2_req_tag,
             o_l1d_wr_valid, o_l1d_wr_paddr, o_l1d_wr_data, o_lrq_resolve_valid, o_lrq_resolve_index_oh, o_lrq_full
   );
   modport master (
      output i_req_valid, i_req_paddr, i_l2_req_ready, i_l2_resp_valid, i_l2_resp_tag, i_l2_resp_data,
      input  o_resp_typ, o_resp_index_oh, o_l2_req_valid, o_l2_req_paddr, o_l2_req_tag,
             o_l1d_wr_valid, o_l1d_wr_paddr, o_l1d_wr_data, o_lrq_resolve_valid, o_lrq_resolve_index_oh, o_lrq_full
   );
endinterface

// File: rtl/msrh_lrq_miss_queue.sv
// msrh_lrq_miss_queue: L1D load miss queue; allocates line misses, refills from L2, fills L1D and resolves waiters.
module msrh_lrq_miss_queue #(
   parameter int LRQ_SIZE     = 4,
   parameter int LSU_INST_NUM = 2,
   parameter int PADDR_W      = 56,
   parameter int LINE_BYTES   = 64,
   parameter int LINE_W       = 512
) (
   input logic                  i_clk,
   input logic                  i_reset,
   msrh_lrq_miss_queue_if.slave bus
);
   localparam int OFF   = $clog2(LINE_BYTES);
   localparam int LA_W  = PADDR_W - OFF;
   localparam int TAG_W = $clog2(LRQ_SIZE);

   typedef enum logic [1:0] {INIT, REQ, WAIT_RESP, FILL} state_t;

   state_t                    state_q [LRQ_SIZE];
   state_t                    state_d [LRQ_SIZE];
   logic [LA_W-1:0]           line_q  [LRQ_SIZE];
   logic [LA_W-1:0]           line_d  [LRQ_SIZE];
   logic                      lock_q, lock_d;
   logic [TAG_W-1:0]          lock_tag_q, lock_tag_d;
   logic                      fill_valid_q, fill_valid_d;
   logic [TAG_W-1:0]          fill_tag_q, fill_tag_d;
   logic [LA_W-1:0]           fill_line_q, fill_line_d;
   logic [LINE_W-1:0]         fill_data_q, fill_data_d;
   logic [LRQ_SIZE-1:0]       free, req_vec, taken, hit;
   logic [TAG_W-1:0]          req_tag, l2_tag, sel;
   logic                      l2_valid, l2_hs, found;
   logic [LA_W-1:0]           la;
   logic [LSU_INST_NUM*2-1:0] resp_typ;
   logic [LSU_INST_NUM*LRQ_SIZE-1:0] resp_oh;

   always_comb begin
      free    = '0;
      req_vec = '0;
      req_tag = '0;
      for (int i = LRQ_SIZE - 1; i >= 0; i--) begin
         free[i]    = state_q[i] == INIT;
         req_vec[i] = state_q[i] == REQ;
         if (req_vec[i]) req_tag = TAG_W'(i);
      end
      // a stalled request keeps its entry so paddr/tag stay stable until accepted
      l2_tag     = lock_q ? lock_tag_q : req_tag;
      l2_valid   = |req_vec;
      l2_hs      = l2_valid && bus.i_l2_req_ready;
      lock_d     = l2_valid && !bus.i_l2_req_ready;
      lock_tag_d = l2_tag;
   end

   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      taken        = '0;
      hit          = '0;
      sel          = '0;
      found        = 1'b0;
      la           = '0;
      resp_typ     = '0;
      resp_oh      = '0;
      fill_valid_d = bus.i_l2_resp_valid && state_q[bus.i_l2_resp_tag] == WAIT_RESP;
      fill_tag_d   = fill_valid_d ? bus.i_l2_resp_tag : fill_tag_q;
      fill_line_d  = fill_valid_d ? line_q[bus.i_l2_resp_tag] : fill_line_q;
      fill_data_d  = fill_valid_d ? bus.i_l2_resp_data : fill_data_q;
      if (fill_valid_q) state_d[fill_tag_q] = INIT;
      if (l2_hs) state_d[l2_tag] = WAIT_RESP;
      if (fill_valid_d) state_d[bus.i_l2_resp_tag] = FILL;
      // line_d of an entry taken by an earlier pipe already holds its new line
      for (int p = 0; p < LSU_INST_NUM; p++) begin
         la    = bus.i_req_paddr[p*PADDR_W+OFF +: LA_W];
         found = 1'b0;
         sel   = '0;
         for (int i = LRQ_SIZE - 1; i >= 0; i--) begin
            hit[i] = (state_q[i] != INIT || taken[i]) && line_d[i] == la;
            if (free[i] && !taken[i]) begin
               found = 1'b1;
               sel   = TAG_W'(i);
            end
         end
         if (bus.i_req_valid[p]) begin
            resp_typ[p*2 +: 2]             = |hit ? 2'd2 : found ? 2'd1 : 2'd3;
            resp_oh[p*LRQ_SIZE +: LRQ_SIZE] = hit;
            if (!(|hit) && found) begin
               taken[sel]   = 1'b1;
               line_d[sel]  = la;
               state_d[sel] = REQ;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < LRQ_SIZE; i++) begin
            state_q[i] <= INIT;
            line_q[i]  <= '0;
         end
         lock_q       <= 1'b0;
         lock_tag_q   <= '0;
         fill_valid_q <= 1'b0;
         fill_tag_q   <= '0;
         fill_line_q  <= '0;
         fill_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         line_q       <= line_d;
         lock_q       <= lock_d;
         lock_tag_q   <= lock_tag_d;
         fill_valid_q <= fill_valid_d;
         fill_tag_q   <= fill_tag_d;
         fill_line_q  <= fill_line_d;
         fill_data_q  <= fill_data_d;
      end
   end

`ifdef SIMULATION
   logic first_q;
   always_ff @(posedge i_clk) begin
      first_q <= i_reset;
      if (!i_reset && !first_q && bus.i_l2_resp_valid && state_q[bus.i_l2_resp_tag] != WAIT_RESP)
         $fatal(1, "lrq: L2 response tag %0d names an entry not waiting for a refill", bus.i_l2_resp_tag);
   end
`endif

   assign bus.o_resp_typ             = resp_typ;
   assign bus.o_resp_index_oh        = resp_oh;
   assign bus.o_l2_req_valid         = l2_valid;
   assign bus.o_l2_req_paddr         = {line_q[l2_tag], {OFF{1'b0}}};
   assign bus.o_l2_req_tag           = l2_tag;
   assign bus.o_l1d_wr_valid         = fill_valid_q;
   assign bus.o_l1d_wr_paddr         = {fill_line_q, {OFF{1'b0}}};
   assign bus.o_l1d_wr_data          = fill_data_q;
   assign bus.o_lrq_resolve_valid    = fill_valid_q;
   assign bus.o_lrq_resolve_index_oh = fill_valid_q ? LRQ_SIZE'(1) << fill_tag_q : '0;
   assign bus.o_lrq_full             = ~|free;
endmodule

// File: tb/tb_msrh_lrq_miss_queue.sv
// tb_msrh_lrq_miss_queue: directed stimulus with a scoreboard of expected responses, L2 requests and fills.
module tb_msrh_lrq_miss_queue;
   localparam int N  = 4;
   localparam int P  = 2;
   localparam int AW = 56;
   localparam int LW = 512;

   typedef struct packed {
      logic [AW-1:0] pa;
      logic [LW-1:0] d;
      logic [N-1:0]  oh;
   } fill_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [6:0]    rq [$];
   logic [AW+1:0] lq [$];
   fill_t         fq [$];
   logic [6:0]    re;
   logic [AW+1:0] le;
   fill_t         fe;

   always #5 clk = ~clk;

   msrh_lrq_miss_queue_if #(.LRQ_SIZE(N), .LSU_INST_NUM(P), .PADDR_W(AW), .LINE_W(LW)) bus ();

   msrh_lrq_miss_queue #(.LRQ_SIZE(N), .LSU_INST_NUM(P), .PADDR_W(AW), .LINE_BYTES(64), .LINE_W(LW)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   function automatic logic [LW-1:0] dat(input int k);
      return {16{32'hD0A0_0000 + 32'(k)}};
   endfunction

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
      bus.i_req_valid     = '0;
      bus.i_req_paddr     = '0;
      bus.i_l2_resp_valid = 1'b0;
      bus.i_l2_resp_tag   = '0;
      bus.i_l2_resp_data  = '0;
   endtask

   task automatic issue(input int p, input logic [AW-1:0] a, input logic [1:0] t, input logic [N-1:0] oh);
      bus.i_req_valid[p]         = 1'b1;
      bus.i_req_paddr[p*AW +: AW] = a;
      rq.push_back({1'(p), t, oh});
   endtask

   task automatic l2exp(input logic [AW-1:0] a, input logic [1:0] tag);
      lq.push_back({a, tag});
   endtask

   task automatic resp(input logic [1:0] tag, input logic [AW-1:0] a, input int k);
      bus.i_l2_resp_valid = 1'b1;
      bus.i_l2_resp_tag   = tag;
      bus.i_l2_resp_data  = dat(k);
      fq.push_back({a, dat(k), 4'b0001 << tag});
   endtask

   task automatic stall_chk(input string name);
      check({name, "_valid"}, LW'(bus.o_l2_req_valid), LW'(1));
      check({name, "_paddr"}, LW'(bus.o_l2_req_paddr), LW'(56'h3000));
      check({name, "_tag"}, LW'(bus.o_l2_req_tag), LW'(1));
   endtask

   always @(negedge clk) begin
      for (int p = 0; p < P; p++) begin
         if (bus.o_resp_typ[p*2 +: 2] != 2'd0) begin
            if (rq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: pipe %0d typ %0d, none expected", p, bus.o_resp_typ[p*2 +: 2]);
            end else begin
               re = rq.pop_front();
               check("resp_pipe", LW'(p), LW'(re[6]));
               check("resp_typ", LW'(bus.o_resp_typ[p*2 +: 2]), LW'(re[5:4]));
               check("resp_oh", LW'(bus.o_resp_index_oh[p*N +: N]), LW'(re[3:0]));
            end
         end
      end
      if (bus.o_l2_req_valid && bus.i_l2_req_ready) begin
         if (lq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL l2_unexpected: paddr %0h tag %0d, none expected", bus.o_l2_req_paddr, bus.o_l2_req_tag);
         end else begin
            le = lq.pop_front();
            check("l2_paddr", LW'(bus.o_l2_req_paddr), LW'(le[AW+1:2]));
            check("l2_tag", LW'(bus.o_l2_req_tag), LW'(le[1:0]));
         end
      end
      if (bus.o_l1d_wr_valid || bus.o_lrq_resolve_valid) begin
         if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fill_unexpected: wr %0b resolve %0b oh %0h, none expected",
                     bus.o_l1d_wr_valid, bus.o_lrq_resolve_valid, bus.o_lrq_resolve_index_oh);
         end else begin
            fe = fq.pop_front();
            check("fill_wr_valid", LW'(bus.o_l1d_wr_valid), LW'(1));
            check("fill_resolve_valid", LW'(bus.o_lrq_resolve_valid), LW'(1));
            check("fill_resolve_oh", LW'(bus.o_lrq_resolve_index_oh), LW'(fe.oh));
            check("fill_paddr", LW'(bus.o_l1d_wr_paddr), LW'(fe.pa));
            check("fill_data", bus.o_l1d_wr_data, fe.d);
         end
      end
   end

   initial begin
      bus.i_req_valid     = '0;
      bus.i_req_paddr     = '0;
      bus.i_l2_req_ready  = 1'b1;
      bus.i_l2_resp_valid = 1'b0;
      bus.i_l2_resp_tag   = '0;
      bus.i_l2_resp_data  = '0;
      step;
      step;
      check("rst_typ", LW'(bus.o_resp_typ), '0);
      check("rst_l2_valid", LW'(bus.o_l2_req_valid), '0);
      check("rst_wr_valid", LW'(bus.o_l1d_wr_valid), '0);
      check("rst_resolve", LW'(bus.o_lrq_resolve_valid), '0);
      check("rst_full", LW'(bus.o_lrq_full), '0);
      rst = 1'b0;
      // single miss, then the freed entry 0 is reused
      issue(0, 56'h8000_0048, 2'd1, 4'b0000);
      l2exp(56'h8000_0040, 2'd0);
      step;
      step;
      resp(2'd0, 56'h8000_0040, 1);
      step;
      step;
      issue(0, 56'h9000_0000, 2'd1, 4'b0000);
      l2exp(56'h9000_0000, 2'd0);
      step;
      step;
      resp(2'd0, 56'h9000_0000, 2);
      step;
      step;
      // same line on both pipes in one cycle
      issue(0, 56'h1000, 2'd1, 4'b0000);
      issue(1, 56'h1020, 2'd2, 4'b0001);
      l2exp(56'h1000, 2'd0);
      step;
      step;
      resp(2'd0, 56'h1000, 3);
      step;
      step;
      // fill all entries, FULL, resolving entry not yet free, back-to-back responses
      issue(0, 56'hA000, 2'd1, 4'b0000);
      issue(1, 56'hB000, 2'd1, 4'b0000);
      l2exp(56'hA000, 2'd0);
      l2exp(56'hB000, 2'd1);
      l2exp(56'hC000, 2'd2);
      l2exp(56'hD000, 2'd3);
      step;
      issue(0, 56'hC000, 2'd1, 4'b0000);
      issue(1, 56'hD000, 2'd1, 4'b0000);
      step;
      check("full_set", LW'(bus.o_lrq_full), LW'(1));
      issue(0, 56'hE000, 2'd3, 4'b0000);
      issue(1, 56'hB020, 2'd2, 4'b0010);
      step;
      step;
      step;
      resp(2'd2, 56'hC000, 4);
      step;
      check("full_during_resolve", LW'(bus.o_lrq_full), LW'(1));
      issue(0, 56'hF000, 2'd3, 4'b0000);
      step;
      check("full_clear", LW'(bus.o_lrq_full), LW'(0));
      issue(0, 56'hF000, 2'd1, 4'b0000);
      l2exp(56'hF000, 2'd2);
      step;
      resp(2'd0, 56'hA000, 5);
      step;
      resp(2'd1, 56'hB000, 6);
      step;
      resp(2'd3, 56'hD000, 7);
      step;
      resp(2'd2, 56'hF000, 8);
      step;
      step;
      // L2 backpressure holds entry 1 while entry 0 is reallocated
      issue(0, 56'h2000, 2'd1, 4'b0000);
      l2exp(56'h2000, 2'd0);
      step;
      issue(0, 56'h3000, 2'd1, 4'b0000);
      step;
      bus.i_l2_req_ready = 1'b0;
      resp(2'd0, 56'h2000, 9);
      stall_chk("stall0");
      step;
      stall_chk("stall1");
      step;
      issue(0, 56'h4000, 2'd1, 4'b0000);
      stall_chk("stall2");
      step;
      stall_chk("stall3");
      step;
      stall_chk("stall4");
      step;
      bus.i_l2_req_ready = 1'b1;
      l2exp(56'h3000, 2'd1);
      l2exp(56'h4000, 2'd0);
      step;
      step;
      resp(2'd1, 56'h3000, 10);
      step;
      resp(2'd0, 56'h4000, 11);
      step;
      step;
      // conflict against the entry resolving this cycle
      issue(0, 56'h5000, 2'd1, 4'b0000);
      issue(1, 56'h5040, 2'd1, 4'b0000);
      l2exp(56'h5000, 2'd0);
      l2exp(56'h5040, 2'd1);
      l2exp(56'h5080, 2'd2);
      l2exp(56'h50C0, 2'd3);
      step;
      issue(0, 56'h5080, 2'd1, 4'b0000);
      issue(1, 56'h50C0, 2'd1, 4'b0000);
      step;
      step;
      step;
      step;
      resp(2'd3, 56'h50C0, 12);
      step;
      issue(0, 56'h50C8, 2'd2, 4'b1000);
      step;
      issue(0, 56'h50C0, 2'd1, 4'b0000);
      l2exp(56'h50C0, 2'd3);
      resp(2'd0, 56'h5000, 13);
      step;
      resp(2'd1, 56'h5040, 14);
      step;
      resp(2'd2, 56'h5080, 15);
      step;
      resp(2'd3, 56'h50C0, 16);
      step;
      step;
      // reset with a refill outstanding; the late response is dropped
      issue(0, 56'h6000, 2'd1, 4'b0000);
      l2exp(56'h6000, 2'd0);
      step;
      step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      bus.i_l2_resp_valid = 1'b1;
      bus.i_l2_resp_tag   = 2'd0;
      bus.i_l2_resp_data  = dat(17);
      step;
      check("rst_mid_wr_valid", LW'(bus.o_l1d_wr_valid), '0);
      check("rst_mid_resolve", LW'(bus.o_lrq_resolve_valid), '0);
      check("rst_mid_typ", LW'(bus.o_resp_typ), '0);
      check("rst_mid_l2_valid", LW'(bus.o_l2_req_valid), '0);
      check("rst_mid_full", LW'(bus.o_lrq_full), '0);
      step;
      step;
      step;
      check("sb_resp_left", LW'(rq.size()), '0);
      check("sb_l2_left", LW'(lq.size()), '0);
      check("sb_fill_left", LW'(fq.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
